// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: fetch sequencer for the monocycle MIPS core.
// The block owns the word-indexed PC and drives it straight onto imem_addr.
// Each returned word is captured with its PC in a 2-entry queue.
// Decode drains the queue through inst_valid/inst_ready.
// A redirect flushes the queue and restarts fetch at redirect_pc.
// Optional feature: define FETCH_CNT_EN to add the 32-bit fetch_cnt push counter.
module inst_fetch_ctrl #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [PC_W-1:0] inst_pc
`ifdef FETCH_CNT_EN
  ,
  output logic [31:0]     fetch_cnt
`endif
);

  localparam int unsigned DEPTH = 2;

  logic [PC_W-1:0] pc_reg;
  logic [1:0]      count_reg;
  logic            pop;
  logic            push;
  logic [1:0]      wr_idx;

  // Entry 0 is always the head; a pop shifts entry 1 down into entry 0.
  logic [PC_W-1:0] slot_pc   [DEPTH];
  logic [31:0]     slot_data [DEPTH];

  assign inst_valid = (count_reg != 2'd0);
  assign pop        = inst_valid & inst_ready;
  assign push       = fetch_en & ~redirect_valid & ((count_reg != 2'd2) | pop);

  // After the shift caused by a pop, the first free slot is count - pop.
  assign wr_idx     = count_reg - {1'b0, pop};

  assign imem_addr  = pc_reg;
  assign inst_pc    = slot_pc[0];
  assign inst_data  = slot_data[0];

  // PC register: redirect outranks fetch, reset outranks both.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= RESET_PC;
    end else if (redirect_valid) begin
      pc_reg <= redirect_pc;
    end else if (push) begin
      pc_reg <= pc_reg + PC_W'(1);
    end
  end

  // Occupancy: a simultaneous push and pop leave it unchanged; redirect empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= 2'd0;
    end else if (redirect_valid) begin
      count_reg <= 2'd0;
    end else if (push && !pop) begin
      count_reg <= count_reg + 2'd1;
    end else if (pop && !push) begin
      count_reg <= count_reg - 2'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      // Source of the shift-down on pop; the last slot keeps its own (now stale) value.
      localparam int SRC = (gi + 1 < DEPTH) ? gi + 1 : gi;

      logic [PC_W-1:0] ent_pc_reg;
      logic [31:0]     ent_data_reg;

      // Queue slot: load the fetched word when it is the write target, else shift on pop.
      always_ff @(posedge clk) begin
        if (rst) begin
          ent_pc_reg   <= '0;
          ent_data_reg <= '0;
        end else if (!redirect_valid) begin
          if (push && (wr_idx == 2'(gi))) begin
            ent_pc_reg   <= pc_reg;
            ent_data_reg <= imem_data;
          end else if (pop) begin
            ent_pc_reg   <= slot_pc[SRC];
            ent_data_reg <= slot_data[SRC];
          end
        end
      end

      assign slot_pc[gi]   = ent_pc_reg;
      assign slot_data[gi] = ent_data_reg;
    end
  endgenerate

`ifdef FETCH_CNT_EN
  logic [31:0] fetch_cnt_reg;

  // Push counter: unaffected by pops and redirects, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_reg <= 32'd0;
    end else if (push) begin
      fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_reg;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl. The bench models a combinational instruction
// memory; optional fetch_cnt checks follow FETCH_CNT_EN.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef FETCH_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  inst_fetch_ctrl #(.PC_W(32), .RESET_PC(32'd0)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
`ifdef FETCH_CNT_EN
    ,
    .fetch_cnt      (fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory contents: listed words, everything else a filler pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'd0:   mem_word = 32'h00221820;
      32'd1:   mem_word = 32'h00221822;
      32'd2:   mem_word = 32'h00221824;
      32'd3:   mem_word = 32'h00221825;
      32'd19:  mem_word = 32'h00200008;
      default: mem_word = 32'hA5000000 ^ a;
    endcase
  endfunction

  always_comb imem_data = mem_word(imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] data);
    check({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
    check({tag, "_pc"}, inst_pc, pc);
    check({tag, "_data"}, inst_data, data);
    $display("head %s: pc=%h data=%h addr=%h", tag, inst_pc, inst_data, imem_addr);
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    tick(); tick();

    // Reset state
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_data", inst_data, 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
`ifdef FETCH_CNT_EN
    check("rst_cnt", fetch_cnt, 32'd0);
`endif

    // Free run: first valid one cycle after release, PCs 0..3 back-to-back
    rst = 1'b0; fetch_en = 1'b1; inst_ready = 1'b1;
    #1;
    check("fr_lat0_valid", {31'd0, inst_valid}, 32'd0);
    tick(); check_head("fr0", 32'd0, 32'h00221820);
    check("fr0_addr", imem_addr, 32'd1);
    tick(); check_head("fr1", 32'd1, 32'h00221822);
    tick(); check_head("fr2", 32'd2, 32'h00221824);
    tick(); check_head("fr3", 32'd3, 32'h00221825);

    // Backpressure: ready low for 5 cycles after reset
    rst = 1'b1; tick();
    rst = 1'b0; inst_ready = 1'b0;
    tick(); check_head("bp1", 32'd0, 32'h00221820); check("bp1_addr", imem_addr, 32'd1);
    tick(); check("bp2_addr", imem_addr, 32'd2);
    tick(); check("bp3_addr", imem_addr, 32'd2);
    tick(); check("bp4_addr", imem_addr, 32'd2);
    tick(); check("bp5_addr", imem_addr, 32'd2);
    check_head("bp5", 32'd0, 32'h00221820);
    inst_ready = 1'b1;
    tick(); check_head("bp_rel1", 32'd1, 32'h00221822);
    tick(); check_head("bp_rel2", 32'd2, 32'h00221824);
    tick(); check_head("bp_rel3", 32'd3, 32'h00221825);

    // Fill queue at PC 5, then redirect to 19 in the same cycle as a pop
    inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'd5;
    tick(); redirect_valid = 1'b0;
    check("rd5_valid", {31'd0, inst_valid}, 32'd0);
    check("rd5_addr", imem_addr, 32'd5);
    tick(); check_head("rd5_h", 32'd5, mem_word(32'd5));
    tick(); check("rd5_full_addr", imem_addr, 32'd7);
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd19;
    tick(); redirect_valid = 1'b0;
    check("rd19_valid", {31'd0, inst_valid}, 32'd0);
    check("rd19_addr", imem_addr, 32'd19);
    tick(); check_head("rd19_h", 32'd19, 32'h00200008);
    tick(); check_head("rd20_h", 32'd20, mem_word(32'd20));

    // fetch_en low for 3 cycles while draining a full queue
    inst_ready = 1'b0;
    tick(); check("fe_full_addr", imem_addr, 32'd22);
    fetch_en = 1'b0; inst_ready = 1'b1;
    tick(); check_head("fe1", 32'd21, mem_word(32'd21)); check("fe1_addr", imem_addr, 32'd22);
    tick(); check("fe2_valid", {31'd0, inst_valid}, 32'd0); check("fe2_addr", imem_addr, 32'd22);
    tick(); check("fe3_valid", {31'd0, inst_valid}, 32'd0); check("fe3_addr", imem_addr, 32'd22);
    fetch_en = 1'b1;
    tick(); check_head("fe_resume", 32'd22, mem_word(32'd22));
    check("fe_resume_addr", imem_addr, 32'd23);

    // Wrap: redirect to all-ones straight after a reset
    rst = 1'b1; tick();
    rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFF;
    tick(); redirect_valid = 1'b0;
    check("wr_valid", {31'd0, inst_valid}, 32'd0);
    check("wr_addr", imem_addr, 32'hFFFFFFFF);
`ifdef FETCH_CNT_EN
    check("wr_cnt0", fetch_cnt, 32'd0);
`endif
    tick(); check_head("wr_h0", 32'hFFFFFFFF, mem_word(32'hFFFFFFFF));
    check("wr_h0_addr", imem_addr, 32'd0);
    tick(); check_head("wr_h1", 32'd0, 32'h00221820);
`ifdef FETCH_CNT_EN
    check("wr_cnt2", fetch_cnt, 32'd2);
`endif

    // Reset with full queue and simultaneous redirect: reset wins
    inst_ready = 1'b0;
    tick(); check("rr_full_addr", imem_addr, 32'd2);
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd19;
    tick();
    check("rr_valid", {31'd0, inst_valid}, 32'd0);
    check("rr_addr", imem_addr, 32'd0);
    check("rr_data", inst_data, 32'd0);
    check("rr_pc", inst_pc, 32'd0);
`ifdef FETCH_CNT_EN
    check("rr_cnt", fetch_cnt, 32'd0);
`endif
    rst = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b1;
    tick(); check_head("rr_first", 32'd0, 32'h00221820);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Fetch sequencer for the monocycle MIPS core. It owns the program counter, drives the word address into the combinational instruction memory, and captures each returned instruction with its PC in a 2-entry queue. The decode stage drains the queue through a valid/ready handshake. Branch, jump and `jr` redirects flush the queue and restart fetch at the new PC.

## Interface
Parameters:
- `PC_W`, default 32: program counter and address width.
- `RESET_PC`, default 0: word address of the first fetch after reset.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `fetch_en`, input, 1: fetch permitted when 1; when 0, the PC holds and nothing is pushed.
- `imem_addr`, output, PC_W: word address to instruction memory; always equals the PC register.
- `imem_data`, input, 32: instruction memory read data, valid in the same cycle as `imem_addr`.
- `redirect_valid`, input, 1: one-cycle request to restart fetch at `redirect_pc`.
- `redirect_pc`, input, PC_W: target word address.
- `inst_valid`, output, 1: the queue head is valid.
- `inst_ready`, input, 1: decode accepts the head.
- `inst_data`, output, 32: instruction at the queue head.
- `inst_pc`, output, PC_W: word address of the queue head.
- `fetch_cnt`, output, 32: number of pushed instructions. Present only with `FETCH_CNT_EN`.

## Operation
- The PC is word-indexed and increments by 1 per fetch. Arithmetic is modulo 2^PC_W, so all-ones wraps to 0.
- Queue:
  - 2 entries, each holding {pc, data}, with `count` in 0..2.
  - The head drives `inst_*`. `inst_valid = (count != 0)`.
- pop = `inst_valid & inst_ready`.
- push = `fetch_en & ~redirect_valid & (count < 2 | pop)`.
  - On push, store {PC, `imem_data`} and set PC to PC+1.
  - A push and a pop in the same cycle leave `count` unchanged. The push into a full queue is legal only because of that simultaneous pop.
- Redirect has highest priority:
  - `count` is set to 0, PC is set to `redirect_pc`, and no push occurs.
  - A pop in the same cycle counts as a completed handshake: the consumer has taken the instruction.
- `fetch_en` = 0: PC and queue contents hold. Pops continue. A redirect is still honoured.
- Simultaneous `rst` and `redirect_valid`: reset wins.
- Entries are never dropped except by redirect or reset.
- Reset values:
  - PC = `RESET_PC`; `imem_addr` = `RESET_PC`.
  - `count` = 0, `inst_valid` = 0, `inst_data` = 0, `inst_pc` = 0.
  - `fetch_cnt` = 0.

## Timing
- Fetch latency: with `rst` low in cycle N and `fetch_en` = 1, the word at `RESET_PC` is sampled in N and appears on `inst_valid`/`inst_data` in N+1.
- Throughput: 1 instruction per cycle while `inst_ready` is held at 1.
- Backpressure: with `inst_ready` = 0, the queue fills after 2 fetches. The PC then stalls on the address of the next unfetched word, and `imem_addr` is stable.
- Redirect:
  - Asserted in cycle R: `inst_valid` = 0 in R+1, and `imem_addr` = `redirect_pc` in R+1.
  - The target instruction is visible in R+2, giving a redirect penalty of 2 cycles.
- Reset mid-operation: all queue contents are discarded on the reset edge, and the next cycle behaves as the first post-reset cycle.
- `inst_*` are registered outputs; there is no combinational path from `inst_ready` to `inst_data`.

## Configuration
- `FETCH_CNT_EN` defined:
  - Adds the `fetch_cnt` port, a 32-bit counter incremented on every push.
  - It is unaffected by pops and redirects, wraps modulo 2^32, and resets to 0.
- `FETCH_CNT_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset then free-run, with memory words 0..3 = 32'h00221820, 32'h00221822, 32'h00221824, 32'h00221825 and `inst_ready` = 1:
  - First `inst_valid` appears 1 cycle after reset release.
  - `inst_pc` = 0,1,2,3 on consecutive cycles, with matching data.
- Backpressure: hold `inst_ready` = 0 for 5 cycles after reset.
  - `count` saturates at 2 and `imem_addr` holds at 2.
  - On release, the pops deliver PC 0,1,2 in order with no gap or duplicate.
- Redirect in the same cycle as a pop, with a full queue at PC 5 and `redirect_pc` = 19:
  - `inst_valid` = 0 next cycle.
  - The following cycle shows `inst_pc` = 19 and `inst_data` = 32'h00200008.
  - PC 5's successor is never delivered.
- `fetch_en` = 0 for 3 cycles while draining:
  - The queue empties and `imem_addr` stays constant.
  - Re-enabling resumes at the held PC.
- Wrap: redirect to 32'hFFFFFFFF.
  - Delivered PCs are FFFFFFFF then 0.
  - With `FETCH_CNT_EN`, `fetch_cnt` advances by exactly 2.
- Reset asserted mid-stream with `count` = 2 and a simultaneous redirect:
  - Next cycle `inst_valid` = 0 and `imem_addr` = `RESET_PC`.
  - `fetch_cnt` = 0.
